// File: rtl/cr_huf_comp_lut_long_pp_if.sv
// Bundle between one long-symbol-table builder, the ping-pong LUT and the
// long encoder. The builder/encoder side uses the master modport, the LUT
// uses the slave modport.
interface cr_huf_comp_lut_long_pp_if #(
  parameter int ADDR_W    = 8,
  parameter int DAT_WIDTH = 24,
  parameter int SEQ_W     = 8
);
  // Builder write stream and back-pressure
  logic                 st_lut_wr;
  logic [ADDR_W-1:0]    st_lut_wr_addr;
  logic [DAT_WIDTH-1:0] st_lut_wr_data;
  logic                 st_lut_wr_done;
  logic [SEQ_W-1:0]     st_lut_seq_id;
  logic                 lut_st_full;
  logic                 lut_wr_err;
  // Encoder lookup side
  logic                 lut_rd_tbl_vld;
  logic [SEQ_W-1:0]     lut_rd_seq_id;
  logic                 enc_lut_rd_req;
  logic [ADDR_W-1:0]    enc_lut_rd_addr;
  logic [DAT_WIDTH-1:0] lut_enc_rd_data;
  logic                 lut_enc_rd_vld;
  logic                 enc_lut_rd_done;

  modport master (
    output st_lut_wr, st_lut_wr_addr, st_lut_wr_data, st_lut_wr_done, st_lut_seq_id,
    output enc_lut_rd_req, enc_lut_rd_addr, enc_lut_rd_done,
    input  lut_st_full, lut_wr_err, lut_rd_tbl_vld, lut_rd_seq_id,
    input  lut_enc_rd_data, lut_enc_rd_vld
  );

  modport slave (
    input  st_lut_wr, st_lut_wr_addr, st_lut_wr_data, st_lut_wr_done, st_lut_seq_id,
    input  enc_lut_rd_req, enc_lut_rd_addr, enc_lut_rd_done,
    output lut_st_full, lut_wr_err, lut_rd_tbl_vld, lut_rd_seq_id,
    output lut_enc_rd_data, lut_enc_rd_vld
  );
endinterface

// File: rtl/cr_huf_comp_lut_long_pp.sv
// Ping-pong code lookup table for the long path. The builder fills one bank
// while the encoder looks codes up in the other; banks are handed over in
// strict write order and the builder is held off when both banks are READY.
module cr_huf_comp_lut_long_pp #(
  parameter int DEPTH     = 249,
  parameter int ADDR_W    = 8,
  parameter int DAT_WIDTH = 24,
  parameter int SEQ_W     = 8
) (
  input logic                     clk,
  input logic                     rst_n,
  cr_huf_comp_lut_long_pp_if.slave lut_if
);

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_READY   = 2'd2
  } bank_state_e;

  bank_state_e          r_state [2];
  bank_state_e          w_state_nxt [2];
  logic                 r_wbank;
  logic                 r_rbank;
  logic [DEPTH-1:0]     r_bitmap [2];
  logic [SEQ_W-1:0]     r_seq [2];
  logic [DAT_WIDTH-1:0] r_mem [2][DEPTH];

  logic                 r_full;
  logic                 r_tbl_vld;
  logic [SEQ_W-1:0]     r_rd_seq_id;
  logic                 r_wr_err;
  logic                 r_rd_vld;
  logic [DAT_WIDTH-1:0] r_rd_data;

  logic w_wr_addr_ok;
  logic w_rd_addr_ok;
  logic w_wr_open;
  logic w_wr_acc;
  logic w_close;
  logic w_wr_drop;
  logic w_release;
  logic w_rd_hit;
  logic w_rbank_ready;

  // Decode the write, close, release and lookup events of this cycle.
  // The write bank is only READY when both banks are READY, i.e. when full.
  always_comb begin
    w_wr_addr_ok  = int'(lut_if.st_lut_wr_addr) < DEPTH;
    w_rd_addr_ok  = int'(lut_if.enc_lut_rd_addr) < DEPTH;
    w_wr_open     = lut_if.st_lut_wr && (r_state[r_wbank] != BANK_READY);
    w_wr_acc      = w_wr_open && w_wr_addr_ok;
    w_close       = w_wr_open && lut_if.st_lut_wr_done;
    w_wr_drop     = lut_if.st_lut_wr && !(w_wr_open && w_wr_addr_ok);
    w_release     = lut_if.enc_lut_rd_done && r_tbl_vld;
    w_rd_hit      = lut_if.enc_lut_rd_req && r_tbl_vld;
    w_rbank_ready = (r_state[r_rbank] == BANK_READY);
  end

  // Per-bank next state. Close and release always target different banks,
  // since close needs a non-READY bank and release needs a READY one.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      w_state_nxt[b] = r_state[b];
      if (w_release && (r_rbank == 1'(b))) begin
        w_state_nxt[b] = BANK_EMPTY;
      end
      if (r_wbank == 1'(b)) begin
        if (w_close) begin
          w_state_nxt[b] = BANK_READY;
        end else if (w_wr_acc && (r_state[b] == BANK_EMPTY)) begin
          w_state_nxt[b] = BANK_FILLING;
        end
      end
    end
  end

  // Bank state registers.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state[0] <= BANK_EMPTY;
      r_state[1] <= BANK_EMPTY;
    end else begin
      r_state[0] <= w_state_nxt[0];
      r_state[1] <= w_state_nxt[1];
    end
  end

  // Bank pointers, written-bitmaps and captured sequence ids.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wbank     <= 1'b0;
      r_rbank     <= 1'b0;
      r_bitmap[0] <= '0;
      r_bitmap[1] <= '0;
      r_seq[0]    <= '0;
      r_seq[1]    <= '0;
    end else begin
      if (w_release) begin
        r_bitmap[r_rbank] <= '0;
        r_rbank           <= ~r_rbank;
      end
      if (w_wr_acc) begin
        r_bitmap[r_wbank][lut_if.st_lut_wr_addr] <= 1'b1;
      end
      if (w_close) begin
        r_seq[r_wbank] <= lut_if.st_lut_seq_id;
        r_wbank        <= ~r_wbank;
      end
    end
  end

  // Table storage; stale words are masked by the bitmap on lookup.
  // NOTE: the entry array is deliberately not reset; the per-bank bitmap
  // is what marks content valid, so the RAM can map onto plain memory.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wbank][lut_if.st_lut_wr_addr] <= lut_if.st_lut_wr_data;
    end
  end

  // Registered status towards builder and encoder. Full follows the next
  // bank states so it tracks "both banks READY" exactly; table-valid drops
  // on the release edge and returns once the next bank is seen READY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full      <= 1'b0;
      r_tbl_vld   <= 1'b0;
      r_rd_seq_id <= '0;
      r_wr_err    <= 1'b0;
    end else begin
      r_full    <= (w_state_nxt[0] == BANK_READY) && (w_state_nxt[1] == BANK_READY);
      r_tbl_vld <= w_rbank_ready && !w_release;
      r_wr_err  <= w_wr_drop;
      if (w_rbank_ready && !w_release) begin
        r_rd_seq_id <= r_seq[r_rbank];
      end
    end
  end

  // Single-cycle lookup; a request alongside release still uses the old bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_vld  <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_rd_vld <= w_rd_hit;
      if (w_rd_hit) begin
        r_rd_data <= (w_rd_addr_ok && r_bitmap[r_rbank][lut_if.enc_lut_rd_addr])
                     ? r_mem[r_rbank][lut_if.enc_lut_rd_addr] : '0;
      end else begin
        r_rd_data <= '0;
      end
    end
  end

  assign lut_if.lut_st_full     = r_full;
  assign lut_if.lut_rd_tbl_vld  = r_tbl_vld;
  assign lut_if.lut_rd_seq_id   = r_rd_seq_id;
  assign lut_if.lut_wr_err      = r_wr_err;
  assign lut_if.lut_enc_rd_vld  = r_rd_vld;
  assign lut_if.lut_enc_rd_data = r_rd_data;

endmodule

// File: doc/cr_huf_comp_lut_long_pp.md
Name: cr_huf_comp_lut_long_pp

Overview:
- Ping-pong code lookup table that sits directly downstream of one long-symbol-table builder instance.
- Captures the builder's LUT write stream (st_lut_wr / addr / data / wr_done) into one of two banks.
- Presents completed tables to the long encoder for per-symbol code lookup, and back-pressures the builder with lut_st_full.
- Instantiated twice in the long path, once per builder.

Parameters:
- DEPTH, 249, number of table entries per bank (long symbol alphabet).
- ADDR_W, 8, write/read address width.
- DAT_WIDTH, 24, entry width (code plus length, opaque to this block).
- SEQ_W, 8, sequence-id width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- st_lut_wr  in  1  write strobe from the builder.
- st_lut_wr_addr  in  ADDR_W  entry index.
- st_lut_wr_data  in  DAT_WIDTH  entry value.
- st_lut_wr_done  in  1  last beat of a table; qualified by st_lut_wr.
- st_lut_seq_id  in  SEQ_W  sequence id; sampled with wr_done.
- lut_st_full  out  1  no writable bank; builder must hold writes.
- lut_rd_tbl_vld  out  1  a completed table is available at the read bank.
- lut_rd_seq_id  out  SEQ_W  seq id of the read-bank table.
- enc_lut_rd_req  in  1  lookup request.
- enc_lut_rd_addr  in  ADDR_W  symbol to look up.
- lut_enc_rd_data  out  DAT_WIDTH  looked-up entry.
- lut_enc_rd_vld  out  1  rd_data valid.
- enc_lut_rd_done  in  1  encoder finished with the read bank.
- lut_wr_err  out  1  one-cycle pulse: write dropped.

Behaviour:
- Two banks, each in state EMPTY, FILLING or READY.
- Pointers: wbank and rbank, 1 bit each.
- Per-bank written-bitmap of DEPTH bits, plus per-bank seq-id register.
- Reset: both banks EMPTY, wbank=rbank=0, bitmaps cleared; every output 0. Reset mid-table discards all content.
- Write acceptance: a write is accepted when st_lut_wr=1, bank[wbank] is EMPTY or FILLING, and addr<DEPTH.
  - Accepted write stores the data and sets its bitmap bit.
  - EMPTY moves to FILLING on the first accepted write.
- Dropped writes: if addr>=DEPTH, or if st_lut_wr arrives while full, the write is dropped and lut_wr_err pulses the next cycle.
  - A dropped write that carries wr_done still closes the bank, unless full.
- Bank close: st_lut_wr & st_lut_wr_done & not full does the following:
  - stores the beat's data;
  - captures seq_id;
  - moves bank[wbank] to READY;
  - toggles wbank.
  - A wr_done on an EMPTY bank (zero-entry table) is legal and makes it READY.
- lut_st_full is registered: it is 1 the cycle after bank[wbank] becomes READY with the other bank not EMPTY.
  - Equivalently, full=1 exactly when both banks are READY.
  - It drops the cycle after a release frees a bank.
- lut_rd_tbl_vld = (bank[rbank]==READY), registered. lut_rd_seq_id reflects the read bank and holds until release.
- Lookup: enc_lut_rd_req while tbl_vld gives rd_vld=1 and rd_data one cycle later (latency 1, one request per cycle, no stall).
  - Returns the stored entry if its bitmap bit is set, else 0.
  - addr>=DEPTH returns 0.
  - A request while tbl_vld=0 is ignored (rd_vld stays 0).
- Release: enc_lut_rd_done while tbl_vld moves bank[rbank] to EMPTY, clears its bitmap and toggles rbank.
  - tbl_vld drops the next cycle and re-asserts the cycle after that if the other bank is READY.
  - A rd_done while tbl_vld=0 is ignored.
  - A rd_req on the same cycle as rd_done is still served from the released bank.
- Simultaneous events:
  - Close of bank A plus release of bank B in the same cycle: both take effect.
  - Release plus a write to the freed bank in the same cycle: not possible, since full already blocks it.
  - A write into FILLING bank A during reads of READY bank B proceeds independently.
- Ordering: tables are consumed strictly in write order. Seq ids pass through unchanged.

Test Plan:
- Reset, then write addr 0..248 with data=addr+1 and wr_done on 248, seq 5. Expect: tbl_vld=1 two cycles later, seq_id=5; read addr 17 returns 18 with rd_vld one cycle later; full=0.
- Fill two tables (seq 1, 2) with no reads. Expect: full=1 after the second wr_done; a further write pulses lut_wr_err and is not stored. rd_done releases bank 0: full=0 next cycle, seq_id=2 one cycle after that.
- Partial table with only addr 3 written, value 0xABC. Expect: read addr 3 returns 0xABC; read addr 4 and addr 250 return 0. After release and rewrite, addr 3 reads 0 unless rewritten.
- wr_done with zero prior writes, seq 9. Expect: tbl_vld=1, seq 9, all reads return 0.
- Same-cycle wr_done (bank 1) and rd_done (bank 0). Expect: both take effect, tbl_vld re-asserts with bank 1's seq id, full never asserts.
- Assert rst_n low mid-fill and mid-read. Expect: all outputs 0 immediately; after release, the first table written reads back correctly in bank 0.
